filter_sched: RTL

FILTER_SCHED -- requirements
Module: filter_sched

---
 rtl/filter_sched.sv | 110 +++++++++++
 1 files changed

// File: rtl/filter_sched.sv
// Shared 3-tap (1,2,1)/4 smoothing filter serving NCH requester channels
// through a rotating-priority grant and a single registered output slot.
module filter_sched #(
  parameter int NCH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [NCH-1:0]   req_valid,
  input  logic [8*NCH-1:0] req_data,
  output logic [NCH-1:0]   req_ready,
  input  logic [NCH-1:0]   chan_en,
  input  logic [NCH-1:0]   chan_clr,
  output logic             out_valid,
  output logic [7:0]       out_data,
  output logic [1:0]       out_chan,
  input  logic             out_ready
);

  localparam int IW = 2;

  logic [7:0]    r_d0 [NCH];
  logic [7:0]    r_d1 [NCH];
  logic [IW-1:0] r_last_grant;
  logic          r_out_valid;
  logic [7:0]    r_out_data;
  logic [IW-1:0] r_out_chan;

  logic           w_can_accept;
  logic [NCH-1:0] w_elig;
  logic [IW-1:0]  w_idx;
  logic [IW-1:0]  w_gidx;
  logic           w_found;
  logic [NCH-1:0] w_grant;
  logic           w_xfer;
  logic [7:0]     w_x;
  logic [7:0]     w_sum;
  logic [7:0]     w_y;

  assign w_can_accept = !r_out_valid || out_ready;
  assign w_elig       = req_valid & chan_en & ~chan_clr;

  // First eligible channel searching upward from the one after the last grant.
  always_comb begin
    w_idx   = '0;
    w_gidx  = '0;
    w_found = 1'b0;
    for (int unsigned k = 0; k < NCH; k++) begin
      w_idx = IW'(r_last_grant + IW'(k) + IW'(1));
      if (!w_found && w_elig[w_idx]) begin
        w_found = 1'b1;
        w_gidx  = w_idx;
      end
    end
  end

  always_comb begin
    w_grant = '0;
    if (w_found && w_can_accept && !RST)
      w_grant[w_gidx] = 1'b1;
  end

  assign req_ready = w_grant;
  assign w_xfer    = |w_grant;

  // Sum wraps at 8 bits before the shift, so no wider accumulator.
  assign w_x   = req_data[{w_gidx, 3'b000} +: 8];
  assign w_sum = w_x + {r_d0[w_gidx][6:0], 1'b0} + r_d1[w_gidx];
  assign w_y   = w_sum >> 2;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        r_d0[i] <= '0;
        r_d1[i] <= '0;
      end
      r_last_grant <= '1;
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        if (chan_clr[i]) begin
          r_d0[i] <= '0;
          r_d1[i] <= '0;
        end else if (w_xfer && (w_gidx == IW'(i))) begin
          r_d1[i] <= r_d0[i];
          r_d0[i] <= w_x;
        end
      end
      if (w_xfer)
        r_last_grant <= w_gidx;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_chan  <= '0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_y;
      r_out_chan  <= w_gidx;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_chan  = r_out_chan;

endmodule
